// File: rtl/cpu_panel_ctrl.sv
// Front panel for the single-cycle CPU. It turns a debounced push-button into single-step
// clock pulses, counts the steps, and scans a selected 32-bit CPU word onto an 8-digit display.
module cpu_panel_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SCAN_DIV        = 4,
   parameter int STEP_HIGH       = 2
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        Step_Key,
   input  logic        Mode_SW,
   input  logic [32:1] PC_Data,
   input  logic [32:1] Output_Data,
   output logic        CPU_Clk,
   output logic [16:1] Step_Count,
   output logic [8:1]  AN,
   output logic [7:1]  Seg
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HI_W = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);
   localparam logic [HI_W-1:0] HI_LAST = HI_W'(STEP_HIGH - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HIGH = 1'b1
   } step_state_t;

   // Two-flop synchronisers: bit 0 carries the key, bit 1 the mode switch.
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic       w_key_sync;
   logic       w_mode_sync;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {Mode_SW, Step_Key};
         r_sync2 <= r_sync1;
      end
   end

   assign w_key_sync  = r_sync2[0];
   assign w_mode_sync = r_sync2[1];

   logic [DB_W-1:0] r_db_cnt;
   logic            r_stable;
   logic            r_stable_d;
   logic            w_press;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_db_cnt   <= '0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
      end else begin
         r_stable_d <= r_stable;
         if (w_key_sync == r_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_stable <= w_key_sync;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   // Only a debounced press is an event; releases just re-arm the button.
   assign w_press = r_stable & ~r_stable_d;

   step_state_t     r_state;
   step_state_t     w_state_next;
   logic [HI_W-1:0] r_hi_cnt;
   logic [HI_W-1:0] w_hi_cnt_next;
   logic            r_cpu_clk;
   logic            w_cpu_clk_next;
   logic [15:0]     r_step_count;
   logic [15:0]     w_step_count_next;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state      <= ST_IDLE;
         r_hi_cnt     <= '0;
         r_cpu_clk    <= 1'b0;
         r_step_count <= '0;
      end else begin
         r_state      <= w_state_next;
         r_hi_cnt     <= w_hi_cnt_next;
         r_cpu_clk    <= w_cpu_clk_next;
         r_step_count <= w_step_count_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_hi_cnt_next     = r_hi_cnt;
      w_step_count_next = r_step_count;
      w_cpu_clk_next    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press) begin
               w_state_next      = ST_HIGH;
               w_hi_cnt_next     = '0;
               w_step_count_next = r_step_count + 16'd1;
            end
         end
         ST_HIGH: begin
            // Presses seen here are dropped: IDLE is the only state that listens.
            if (r_hi_cnt == HI_LAST) begin
               w_state_next  = ST_IDLE;
               w_hi_cnt_next = '0;
            end else begin
               w_hi_cnt_next = r_hi_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      w_cpu_clk_next = (w_state_next == ST_HIGH);
   end

   assign CPU_Clk    = r_cpu_clk;
   assign Step_Count = r_step_count;

   logic [SD_W-1:0] r_div;
   logic [2:0]      r_digit;
   logic [32:1]     r_snapshot;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_div      <= '0;
         r_digit    <= '0;
         r_snapshot <= '0;
      end else if (r_div == SD_LAST) begin
         r_div   <= '0;
         r_digit <= r_digit + 3'd1;
         // Reload only at frame start so a frame never mixes two words.
         if (r_digit == 3'd7) begin
            r_snapshot <= w_mode_sync ? Output_Data : PC_Data;
         end
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   logic [3:0] w_nibbles [8];
   logic [3:0] w_nibble;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi = gi + 1) begin : g_digit
         assign w_nibbles[gi] = r_snapshot[4*gi+4 : 4*gi+1];
         assign AN[gi+1]      = (r_digit != 3'(gi));
      end
   endgenerate

   assign w_nibble = w_nibbles[r_digit];

   always_comb begin
      Seg = 7'h7F;
      case (w_nibble)
         4'h0: Seg = 7'h40;
         4'h1: Seg = 7'h79;
         4'h2: Seg = 7'h24;
         4'h3: Seg = 7'h30;
         4'h4: Seg = 7'h19;
         4'h5: Seg = 7'h12;
         4'h6: Seg = 7'h02;
         4'h7: Seg = 7'h78;
         4'h8: Seg = 7'h00;
         4'h9: Seg = 7'h10;
         4'hA: Seg = 7'h08;
         4'hB: Seg = 7'h03;
         4'hC: Seg = 7'h46;
         4'hD: Seg = 7'h21;
         4'hE: Seg = 7'h06;
         4'hF: Seg = 7'h0E;
         default: Seg = 7'h7F;
      endcase
   end

endmodule

// File: tb/tb_cpu_panel_ctrl.sv
// Scoreboard bench for cpu_panel_ctrl: a frame/press-level model queues expected step pulses
// and display digits; monitors pop and compare whenever the DUT presents a pulse or a new digit.
`timescale 1ns/1ps
module tb_cpu_panel_ctrl;

   localparam int D     = 4;
   localparam int S     = 4;
   localparam int H     = 2;
   localparam int FRAME = 8 * S;

   logic        CLK         = 1'b0;
   logic        RST_n       = 1'b1;
   logic        Step_Key    = 1'b0;
   logic        Mode_SW     = 1'b0;
   logic [31:0] PC_Data     = 32'h0;
   logic [31:0] Output_Data = 32'h0;
   logic        CPU_Clk;
   logic [15:0] Step_Count;
   logic [7:0]  AN;
   logic [6:0]  Seg;

   cpu_panel_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .SCAN_DIV(S),
      .STEP_HIGH(H)
   ) dut (
      .CLK(CLK),
      .RST_n(RST_n),
      .Step_Key(Step_Key),
      .Mode_SW(Mode_SW),
      .PC_Data(PC_Data),
      .Output_Data(Output_Data),
      .CPU_Clk(CPU_Clk),
      .Step_Count(Step_Count),
      .AN(AN),
      .Seg(Seg)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int rcyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, rcyc);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   typedef struct { int at_cyc; logic [7:0] an; logic [6:0] seg; } disp_t;
   typedef struct { int at_cyc; logic [15:0] cnt; } step_t;

   disp_t dq[$];
   step_t sq[$];

   // Reference model state: debounced key level, run length of the opposite level, step total,
   // and the mode switch as seen one and two edges ago.
   logic        m_stable = 1'b0;
   int          m_run    = 0;
   logic [15:0] m_count  = 16'h0;
   logic        m_mode1  = 1'b0;
   logic        m_mode2  = 1'b0;
   step_t       m_step;

   task automatic push_frame(input int start, input logic [31:0] snap);
      disp_t e;
      for (int d = 0; d < 8; d++) begin
         e.at_cyc = start + d * S;
         e.an     = ~(8'(1) << d);
         e.seg    = hex7(snap[4*d +: 4]);
         dq.push_back(e);
      end
   endtask

   always @(posedge CLK) begin
      if (!RST_n) begin
         rcyc     = 0;
         m_stable = 1'b0;
         m_run    = 0;
         m_count  = 16'h0;
         m_mode1  = 1'b0;
         m_mode2  = 1'b0;
         sq.delete();
         dq.delete();
         push_frame(0, 32'h0);
      end else begin
         rcyc++;
         if (Step_Key != m_stable) m_run++;
         else m_run = 0;
         if (m_run == D) begin
            m_stable = Step_Key;
            m_run    = 0;
            if (m_stable) begin
               m_count++;
               m_step.at_cyc = rcyc + 3;
               m_step.cnt    = m_count;
               sq.push_back(m_step);
            end
         end
         if (rcyc % FRAME == 0) push_frame(rcyc, m_mode2 ? Output_Data : PC_Data);
         m_mode2 = m_mode1;
         m_mode1 = Mode_SW;
      end
   end

   logic       prev_clk = 1'b0;
   int         hi_len   = 0;
   logic       first    = 1'b1;
   logic [7:0] cur_an   = 8'h0;
   logic [6:0] cur_seg  = 7'h0;
   step_t      got_step;
   disp_t      got_disp;

   always @(negedge CLK) begin
      if (!RST_n) begin
         prev_clk = 1'b0;
         hi_len   = 0;
         first    = 1'b1;
      end else begin
         if (CPU_Clk && !prev_clk) begin
            if (sq.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pulse: CPU_Clk rose at cycle %0d, model expected none", rcyc);
            end else begin
               got_step = sq.pop_front();
               chk("pulse_rise_cycle", 32'(rcyc), 32'(got_step.at_cyc));
               chk("pulse_step_count", 32'(Step_Count), 32'(got_step.cnt));
               $display("step pulse at cycle %0d, Step_Count=0x%04h", rcyc, Step_Count);
            end
            hi_len = 1;
         end else if (CPU_Clk) begin
            hi_len++;
         end else if (prev_clk) begin
            chk("pulse_width", 32'(hi_len), 32'(H));
         end
         prev_clk = CPU_Clk;

         if (first || AN !== cur_an) begin
            if (dq.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL display_underflow: AN=0x%02h at cycle %0d, model expected no change", AN, rcyc);
            end else begin
               got_disp = dq.pop_front();
               if (!first) chk("digit_change_cycle", 32'(rcyc), 32'(got_disp.at_cyc));
               cur_an  = got_disp.an;
               cur_seg = got_disp.seg;
               if (got_disp.an == 8'hFE)
                  $display("frame digit0 at cycle %0d: AN=0x%02h Seg=0x%02h", rcyc, AN, Seg);
            end
            first = 1'b0;
         end
         chk("digit_an", 32'(AN), 32'(cur_an));
         chk("digit_seg", 32'(Seg), 32'(cur_seg));
      end
   end

   task automatic key_for(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         Step_Key = lvl;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cpu_clk"}, 32'(CPU_Clk), 32'h0);
      chk({tag, "_step_count"}, 32'(Step_Count), 32'h0);
      chk({tag, "_an"}, 32'(AN), 32'hFE);
      chk({tag, "_seg"}, 32'(Seg), 32'h40);
   endtask

   logic got;

   initial begin
      #2 RST_n = 1'b0;
      idle(3);
      check_reset_outputs("reset");
      @(negedge CLK);
      #1 RST_n = 1'b1;

      // Clean presses
      key_for(1'b1, 20);
      key_for(1'b0, 20);
      chk("clean_press_count", 32'(Step_Count), 32'h1);
      key_for(1'b1, 20);
      key_for(1'b0, 20);
      chk("second_press_count", 32'(Step_Count), 32'h2);

      // Bouncy press then a lone short glitch
      for (int i = 0; i < 5; i++) begin
         key_for(1'b1, 2);
         key_for(1'b0, 1);
      end
      key_for(1'b1, 12);
      key_for(1'b0, 12);
      chk("bounce_count", 32'(Step_Count), 32'h3);
      key_for(1'b1, 3);
      key_for(1'b0, 12);
      chk("glitch_count", 32'(Step_Count), 32'h3);

      // Random key activity
      for (int i = 0; i < 40; i++) key_for(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
      key_for(1'b0, 12);
      chk("random_key_count", 32'(Step_Count), 32'(m_count));
      chk("step_queue_drained", 32'(sq.size()), 32'h0);

      // Display: PC word, then mode flip in the middle of a frame
      Mode_SW = 1'b0;
      PC_Data = 32'h0040_001C;
      idle(3 * FRAME);
      Output_Data = 32'hFFFF_FFFF;
      got = 1'b0;
      for (int i = 0; i < 2 * FRAME && !got; i++) begin
         @(negedge CLK);
         if (rcyc % FRAME == 3 * S) got = 1'b1;
      end
      Mode_SW = 1'b1;
      idle(2 * FRAME);

      // Random data and mode changes at random times
      for (int i = 0; i < 12; i++) begin
         PC_Data     = $urandom;
         Output_Data = $urandom;
         Mode_SW     = 1'($urandom_range(0, 1));
         idle(int'($urandom_range(1, 40)));
      end
      idle(FRAME);

      // Step counter wrap
      @(negedge CLK);
      force dut.r_step_count = 16'hFFFF;
      m_count = 16'hFFFF;
      @(negedge CLK);
      release dut.r_step_count;
      @(negedge CLK);
      chk("preload_count", 32'(Step_Count), 32'hFFFF);
      key_for(1'b1, 12);
      key_for(1'b0, 12);
      chk("wrap_count", 32'(Step_Count), 32'h0);

      // Reset while CPU_Clk is high
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge CLK);
         Step_Key = 1'b1;
         if (CPU_Clk) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL pulse_timeout: no CPU_Clk pulse within 40 cycles of a held key");
      end
      #2 RST_n = 1'b0;
      #1 check_reset_outputs("midpulse_reset");
      Step_Key = 1'b0;
      idle(3);
      #1 RST_n = 1'b1;
      idle(3 * FRAME);
      chk("post_reset_count", 32'(Step_Count), 32'h0);
      chk("final_step_queue", 32'(sq.size()), 32'h0);
      n_checks++;
      if (dq.size() > 8) begin
         n_errors++;
         $display("FAIL display_backlog: %0d digits pending, expected at most 8", dq.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
